// File: rtl/corefifo_sync_pkg.sv
// Shared helpers and limits for the multi-channel pointer synchroniser.
package corefifo_sync_pkg;

    localparam int MAX_STAGES = 4;
    localparam int MAX_STABLE = 15;

    // Gray to binary on a zero-extended word: each binary bit is the XOR of
    // the Gray bit at that position and every bit above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits in a word.
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/corefifo_sync_chan.sv
// One channel: synchroniser chain, stability filter and Gray error check.
module corefifo_sync_chan
    import corefifo_sync_pkg::*;
#(
    parameter int W           = 4,
    parameter int NUM_STAGES  = 2,
    parameter int DECODE_GRAY = 1,
    parameter int STABLE_CNT  = 0
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         srstn,
    input  logic [W-1:0] inp,
    input  logic         err_clr,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] bin_out,
    output logic         upd,
    output logic         gray_err,
    output logic         err_sticky
);

    localparam logic [3:0] STABLE_K = 4'(STABLE_CNT);

    logic [W-1:0] stage_reg [NUM_STAGES];
    logic [W-1:0] sync_raw;
    logic [W-1:0] h_reg;
    logic [W-1:0] sync_out_reg;
    logic [W-1:0] load_val;
    logic [3:0]   cnt_reg;
    logic         load;
    logic         upd_reg;
    logic         gray_err_reg;
    logic         err_sticky_reg;
    logic         err_now;

    assign sync_raw = stage_reg[NUM_STAGES-1];

    // First synchroniser flop samples the asynchronous pointer.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)      stage_reg[0] <= '0;
        else if (!srstn) stage_reg[0] <= '0;
        else             stage_reg[0] <= inp;
    end

    genvar gi;
    generate
        for (gi = 1; gi < NUM_STAGES; gi++) begin : g_stage
            // Remaining flops of the chain shift the sample along.
            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn)      stage_reg[gi] <= '0;
                else if (!srstn) stage_reg[gi] <= '0;
                else             stage_reg[gi] <= stage_reg[gi-1];
            end
        end
    endgenerate

    // Output loads every edge when unfiltered, otherwise only once the
    // history register has matched the chain output for STABLE_CNT edges.
    always_comb begin
        load     = 1'b1;
        load_val = sync_raw;
        if (STABLE_CNT != 0) begin
            load     = (cnt_reg == STABLE_K);
            load_val = h_reg;
        end
    end

    // More than one bit flipping between consecutive samples cannot be a
    // legal Gray step; raw data skips the check entirely.
    generate
        if (DECODE_GRAY != 0) begin : g_chk
            assign err_now = (popcount(32'(sync_raw ^ h_reg)) > 1);
            assign bin_out = W'(gray2bin(32'(sync_out_reg)));
        end else begin : g_raw
            assign err_now = 1'b0;
            assign bin_out = sync_out_reg;
        end
    endgenerate

    // History, stability counter, filtered output and status flags.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            h_reg          <= '0;
            cnt_reg        <= '0;
            sync_out_reg   <= '0;
            upd_reg        <= 1'b0;
            gray_err_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else if (!srstn) begin
            h_reg          <= '0;
            cnt_reg        <= '0;
            sync_out_reg   <= '0;
            upd_reg        <= 1'b0;
            gray_err_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            h_reg <= sync_raw;
            if (sync_raw != h_reg)      cnt_reg <= '0;
            else if (cnt_reg < STABLE_K) cnt_reg <= cnt_reg + 4'd1;
            if (load) sync_out_reg <= load_val;
            upd_reg      <= load && (load_val != sync_out_reg);
            gray_err_reg <= err_now;
            if (err_now)      err_sticky_reg <= 1'b1;
            else if (err_clr) err_sticky_reg <= 1'b0;
        end
    end

    assign sync_out   = sync_out_reg;
    assign upd        = upd_reg;
    assign gray_err   = gray_err_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: rtl/corefifo_ptr_sync_multi.sv
// Bank of independent pointer synchronisers, one per channel.
module corefifo_ptr_sync_multi
    import corefifo_sync_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int ADDRWIDTH   = 3,
    parameter int NUM_STAGES  = 2,
    parameter int DECODE_GRAY = 1,
    parameter int STABLE_CNT  = 0
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic                            srstn,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    input  logic [NUM_CH-1:0]               err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_out,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] bin_out,
    output logic [NUM_CH-1:0]               upd,
    output logic [NUM_CH-1:0]               gray_err,
    output logic [NUM_CH-1:0]               err_sticky
);

    localparam int W = ADDRWIDTH + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            corefifo_sync_chan #(
                .W           (W),
                .NUM_STAGES  (NUM_STAGES),
                .DECODE_GRAY (DECODE_GRAY),
                .STABLE_CNT  (STABLE_CNT)
            ) u_chan (
                .clk        (clk),
                .arstn      (arstn),
                .srstn      (srstn),
                .inp        (inp[gi*W +: W]),
                .err_clr    (err_clr[gi]),
                .sync_out   (sync_out[gi*W +: W]),
                .bin_out    (bin_out[gi*W +: W]),
                .upd        (upd[gi]),
                .gray_err   (gray_err[gi]),
                .err_sticky (err_sticky[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_corefifo_ptr_sync_multi.sv
// Directed bench: four configurations of the synchroniser bank.
module tb_corefifo_ptr_sync_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn, srstn;

    // a: defaults (1 ch, 2 stages, Gray, unfiltered)
    logic [3:0] a_inp, a_sync, a_bin;
    logic a_clr, a_upd, a_gerr, a_stk;
    // b: 3 stages, STABLE_CNT=3
    logic [3:0] b_inp, b_sync, b_bin;
    logic b_clr, b_upd, b_gerr, b_stk;
    // c: 4 channels
    logic [15:0] c_inp, c_sync, c_bin;
    logic [3:0] c_clr, c_upd, c_gerr, c_stk;
    // d: raw data, no Gray decode
    logic [3:0] d_inp, d_sync, d_bin;
    logic d_clr, d_upd, d_gerr, d_stk;

    int n_checks = 0;
    int n_errors = 0;

    corefifo_ptr_sync_multi dut_a (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(a_inp), .err_clr(a_clr),
        .sync_out(a_sync), .bin_out(a_bin), .upd(a_upd), .gray_err(a_gerr), .err_sticky(a_stk));

    corefifo_ptr_sync_multi #(.NUM_STAGES(3), .STABLE_CNT(3)) dut_b (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(b_inp), .err_clr(b_clr),
        .sync_out(b_sync), .bin_out(b_bin), .upd(b_upd), .gray_err(b_gerr), .err_sticky(b_stk));

    corefifo_ptr_sync_multi #(.NUM_CH(4)) dut_c (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(c_inp), .err_clr(c_clr),
        .sync_out(c_sync), .bin_out(c_bin), .upd(c_upd), .gray_err(c_gerr), .err_sticky(c_stk));

    corefifo_ptr_sync_multi #(.DECODE_GRAY(0)) dut_d (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(d_inp), .err_clr(d_clr),
        .sync_out(d_sync), .bin_out(d_bin), .upd(d_upd), .gray_err(d_gerr), .err_sticky(d_stk));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watch channel-bank c for any error or stray update on static channels.
    logic mon_en = 1'b0;
    logic c_err_seen = 1'b0;
    logic c_other_upd = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (|c_gerr) c_err_seen = 1'b1;
            if (|(c_upd & 4'b1011)) c_other_upd = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        int upd_cnt;
        arstn = 1'b0; srstn = 1'b1;
        a_inp = '0; b_inp = '0; c_inp = '0; d_inp = '0;
        a_clr = '0; b_clr = '0; c_clr = '0; d_clr = '0;
        #22 arstn = 1'b1;
        step(1);

        // reset state
        check("rst_a_sync", a_sync, 0);
        check("rst_a_upd", a_upd, 0);
        check("rst_a_stk", a_stk, 0);
        check("rst_b_sync", b_sync, 0);
        check("rst_c_sync", c_sync, 0);

        // a: 0->1 appears after 3 edges with upd pulse
        a_inp = 4'h1;
        step(2); check("a_lat_early", a_sync, 0);
        step(1); check("a_lat_sync", a_sync, 1);
        check("a_lat_upd", a_upd, 1);
        check("a_lat_bin", a_bin, 1);
        step(1); check("a_upd_once", a_upd, 0);
        check("a_no_err", a_gerr, 0);

        // a: two-bit Gray jump 0->3 flags an error
        a_inp = 4'h0; step(5);
        check("a_back0", a_sync, 0);
        check("a_stk_clean", a_stk, 0);
        a_inp = 4'h3;
        step(3); check("a_err_pulse", a_gerr, 1);
        check("a_err_stk", a_stk, 1);
        check("a_sync3", a_sync, 3);
        check("a_bin3", a_bin, 2);
        step(1); check("a_err_once", a_gerr, 0);
        check("a_stk_hold", a_stk, 1);
        a_clr = 1'b1; step(1); a_clr = 1'b0;
        check("a_stk_clr", a_stk, 0);
        // clear and new error on the same edge: set wins
        a_inp = 4'h0;
        step(2); a_clr = 1'b1;
        step(1); a_clr = 1'b0;
        check("a_setclr_err", a_gerr, 1);
        check("a_setclr_stk", a_stk, 1);
        step(1); check("a_setclr_hold", a_stk, 1);

        // d: raw mode, two-bit change is not an error, bin_out follows sync_out
        d_inp = 4'h3;
        step(2); check("d_early", d_sync, 0);
        step(1); check("d_sync", d_sync, 3);
        check("d_bin", d_bin, 3);
        check("d_upd", d_upd, 1);
        check("d_gerr", d_gerr, 0);
        check("d_stk", d_stk, 0);

        // b: filtered, latency 3+3+2 = 8 edges
        b_inp = 4'h5;
        step(7); check("b_lat_early", b_sync, 0);
        step(1); check("b_lat_sync", b_sync, 5);
        check("b_lat_upd", b_upd, 1);
        step(1); check("b_upd_once", b_upd, 0);
        step(5);
        // 2-cycle glitch must be filtered out
        b_inp = 4'h7; step(2); b_inp = 4'h5;
        upd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (b_upd) upd_cnt++;
        end
        check("b_glitch_sync", b_sync, 5);
        check("b_glitch_upd", upd_cnt, 0);
        b_inp = 4'h4;
        step(7); check("b_step_early", b_sync, 5);
        step(1); check("b_step_sync", b_sync, 4);
        check("b_step_bin", b_bin, 7);
        check("b_step_upd", b_upd, 1);

        // c: static channels 0,1,3; Gray count on channel 2 with wrap 8->0
        c_inp = 16'h8021;
        step(4);
        check("c_setup_sync", c_sync, 16'h8021);
        check("c_setup_bin", c_bin, 16'hF031);
        mon_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            c_inp[11:8] = gray_tab[i % 16];
            step(4);
            check($sformatf("c_cnt%0d_gray", i), c_sync[11:8], gray_tab[i % 16]);
            check($sformatf("c_cnt%0d_bin", i), c_bin[11:8], i % 16);
            check($sformatf("c_cnt%0d_static", i), {c_sync[15:12], c_sync[7:0]}, 12'h821);
        end
        mon_en = 1'b0;
        check("c_no_gray_err", c_err_seen, 0);
        check("c_no_sticky", c_stk, 0);
        check("c_no_other_upd", c_other_upd, 0);

        // asynchronous reset in the middle of a count
        c_inp[11:8] = 4'h1;
        step(2);
        #2 arstn = 1'b0;
        #1;
        check("arst_c_sync", c_sync, 0);
        check("arst_c_bin", c_bin, 0);
        check("arst_c_upd", c_upd, 0);
        check("arst_a_stk", a_stk, 0);
        check("arst_b_sync", b_sync, 0);
        #2 arstn = 1'b1;
        step(2); check("arst_rec_early", c_sync, 0);
        step(1); check("arst_rec_sync", c_sync, 16'h8121);

        // synchronous reset pulse
        step(2);
        srstn = 1'b0;
        step(1); check("srst_c_sync", c_sync, 0);
        check("srst_c_upd", c_upd, 0);
        check("srst_d_sync", d_sync, 0);
        srstn = 1'b1;
        step(2); check("srst_rec_early", c_sync, 0);
        step(1); check("srst_rec_sync", c_sync, 16'h8121);
        check("srst_rec_upd", c_upd, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
